cmul_arbiter: RTL and testbench
===============================

# cmul_arbiter

Round-robin arbiter and two-stage issue pipeline that shares one Q1.15 complex multiplier (`cmul`) among `NUM_REQ` requesters, such as FFT butterfly twiddle stages and the channel equaliser. Each requester offers an operand pair (A, B) over a valid/ready handshake. One request is granted per cycle. Results return on a single tagged output stream with backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each real/imag component. Must be 16 because the multiplier arithmetic is fixed Q1.15.
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: per-requester operand valid.
- `req_ready`, out, NUM_REQ: per-requester accept. At most one bit is high in any cycle.
- `req_a_real`, `req_a_imag`, `req_b_real`, `req_b_imag`, in, NUM_REQ*DATA_WIDTH each: flattened operands. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accept.
- `out_real`, `out_imag`, out, DATA_WIDTH each: signed Q1.15 product.
- `out_id`, out, ID_W: index of the requester that issued the result.
- `busy`, out, 1: high when either pipeline stage holds valid data.

## Operation
- Stall signal: `adv = !out_valid || out_ready`. Both pipeline stages advance only when `adv` is high.
- Arbitration:
  - Requester i is granted when it is the first asserted `req_valid` bit searching upward, with wrap, from pointer `rr_ptr`.
  - `req_ready[i] = grant[i] & adv`. The grant logic is combinational and independent of `req_ready`.
  - Transfer occurs when `req_valid[i] && req_ready[i]`.
  - On transfer, `rr_ptr` becomes `(i+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- Stage 1 (S1): on `adv`, loads the granted operands and id, and sets `s1_valid` to the transfer flag. If `adv` is high with no transfer, `s1_valid` becomes 0.
- Multiply: `cmul` operates combinationally on the S1 registers.
  - Each of the four 32-bit Q2.30 products is saturated/truncated to Q1.15 independently.
  - A product of 0x8000 × 0x8000 saturates to 0x7FFF.
  - The real output is the difference of two saturated products, the imaginary output their sum. Both are 16-bit two's-complement and wrap with no further saturation.
- Stage 2 (S2, output register): on `adv`, loads the `cmul` result and S1 id, and sets `out_valid <= s1_valid`.
- Requester operands need only be stable in the cycle they transfer. The holding requirement falls on the requester: a requester must hold operands and `req_valid` until it sees `req_ready`.
- Starvation: no requester waits more than NUM_REQ−1 transfers once it has asserted `req_valid` continuously.

## Timing
- Reset values:
  - `rr_ptr` = 0, `s1_valid` = 0, `out_valid` = 0.
  - `out_real`, `out_imag`, `out_id` = 0.
  - `req_ready` = 0 during the reset cycle. It is forced low while `rst` is high.
  - `busy` = 0.
- Latency: a transfer in cycle N gives `out_valid` in cycle N+2 when there is no stall.
- Throughput: one result per cycle with `out_ready` tied high.
- Output stall: while `out_valid && !out_ready`:
  - `out_*` holds stable.
  - S1 holds.
  - All `req_ready` bits are 0.
- Simultaneous events:
  - If several requesters are valid, only the granted one sees `req_ready`.
  - If `out_ready` rises in the same cycle as a new request, the transfer and both stage advances all happen in that cycle.
- Reset mid-operation: in-flight S1 and S2 contents are discarded, with no output produced for them. `rr_ptr` returns to 0.
- `busy = s1_valid | out_valid`.

## Structure
- Shared package `dsp_pkg`:
  - Q1.15 constants `Q15_MAX` = 16'sh7FFF and `Q15_MIN` = 16'sh8000.
  - Typedef `cplx_q15_t`, a packed struct with `re` and `im` fields.
  - Helper function `rr_next(ptr, n)`.
- One sub-module: the existing `cmul` (DATA_WIDTH=16), instantiated once between S1 and S2.
- The arbiter priority search stays inline. No separate module.

## Test plan
- Single request: requester 2 sends A=(0x4000,0), B=(0x4000,0) in cycle 5 → `out_valid` in cycle 7 with (0x2000,0x0000) and `out_id`=2.
- Saturation: A=(0x8000,0), B=(0x8000,0) → (0x7FFF,0x0000). A=(0x4000,0x4000), B=(0x4000,0x4000) → (0x0000,0x4000).
- Fairness: all 4 requesters valid continuously from reset with `out_ready`=1 → grant order 0,1,2,3,0,1,… and `out_id` follows the same sequence one result per cycle.
- Backpressure: `out_ready`=0 for 5 cycles with a full pipeline → `out_*` is stable, all `req_ready` bits are 0, and no result is lost or duplicated after release.
- Pointer hold: only requester 3 valid, then requesters 0 and 3 both valid → requester 0 is granted first (`rr_ptr` wrapped to 0 after 3).
- Reset mid-flight: assert `rst` for one cycle with S1 and S2 both valid → `out_valid`=0 next cycle, no stale result emitted, and the next grant follows `rr_ptr`=0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the Q1.15 datapath blocks.
// Contents:
//   Q15_MAX / Q15_MIN : saturation limits of a signed Q1.15 value
//   cplx_q15_t        : packed complex sample, re in the upper half
//   rr_next           : round-robin pointer increment with wrap at n
package dsp_pkg;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_q15_t;

  // Next round-robin position after ptr, wrapping back to 0 at n.
  function automatic int rr_next(input int ptr, input int n);
    if (ptr + 1 >= n) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/cmul.sv
// Combinational Q1.15 complex multiplier.
// Ports:
//   a_real, a_imag : operand A, signed Q1.15
//   b_real, b_imag : operand B, signed Q1.15
//   y_real, y_imag : A*B, signed Q1.15
// Each partial product is brought back to Q1.15 on its own (truncate and
// saturate); the final add/subtract wraps in 16 bits.
module cmul
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a_real,
  input  logic signed [DATA_WIDTH-1:0] a_imag,
  input  logic signed [DATA_WIDTH-1:0] b_real,
  input  logic signed [DATA_WIDTH-1:0] b_imag,
  output logic signed [DATA_WIDTH-1:0] y_real,
  output logic signed [DATA_WIDTH-1:0] y_imag
);

  // Q2.30 -> Q1.15: arithmetic shift drops the fraction (truncation toward
  // minus infinity); only -1 * -1 can exceed the range and clamps to Q15_MAX.
  function automatic logic signed [15:0] sat_q15(input logic signed [31:0] prod);
    logic signed [31:0] shifted;
    shifted = prod >>> 15;
    if (shifted > 32'sd32767) begin
      return Q15_MAX;
    end else if (shifted < -32'sd32768) begin
      return Q15_MIN;
    end
    return shifted[15:0];
  endfunction

  logic signed [2*DATA_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_WIDTH-1:0]   s_rr, s_ii, s_ri, s_ir;

  assign p_rr = 32'(a_real) * 32'(b_real);
  assign p_ii = 32'(a_imag) * 32'(b_imag);
  assign p_ri = 32'(a_real) * 32'(b_imag);
  assign p_ir = 32'(a_imag) * 32'(b_real);

  assign s_rr = sat_q15(p_rr);
  assign s_ii = sat_q15(p_ii);
  assign s_ri = sat_q15(p_ri);
  assign s_ir = sat_q15(p_ir);

  assign y_real = s_rr - s_ii;
  assign y_imag = s_ri + s_ir;

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin arbiter feeding a shared Q1.15 complex multiplier through a
// two-stage pipeline (S1 operand register, S2 output register).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : per-requester handshake (one-hot ready)
//   req_{a,b}_{real,imag}    : flattened operands, requester i at [i*DW +: DW]
//   out_valid / out_ready    : result handshake with backpressure
//   out_real, out_imag       : Q1.15 product
//   out_id                   : index of the requester that issued the result
//   busy                     : either pipeline stage holds valid data
module cmul_arbiter
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_imag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_imag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_real,
  output logic [DATA_WIDTH-1:0]         out_imag,
  output logic [ID_W-1:0]               out_id,
  output logic                          busy
);

  logic                  adv;
  logic                  xfer;
  logic                  found;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant;
  cplx_q15_t             sel_a, sel_b;
  cplx_q15_t             s1_a, s1_b;
  logic                  s1_valid;
  logic [ID_W-1:0]       s1_id;
  logic [DATA_WIDTH-1:0] prod_real, prod_imag;

  // Both stages move together; the only stall source is the output register.
  assign adv = !out_valid || out_ready;

  // Priority search from rr_ptr upward with wrap, done as two ordered passes:
  // first the indices at or above the pointer, then the ones below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) < rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  assign req_ready = rst ? '0 : (grant & {NUM_REQ{adv}});
  assign xfer      = found && adv && !rst;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a.re = req_a_real[i*DATA_WIDTH +: DATA_WIDTH];
        sel_a.im = req_a_imag[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b.re = req_b_real[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b.im = req_b_imag[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  cmul #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmul (
    .a_real(s1_a.re),
    .a_imag(s1_a.im),
    .b_real(s1_b.re),
    .b_imag(s1_b.im),
    .y_real(prod_real),
    .y_imag(prod_imag)
  );

  // Pointer, S1 and S2 registers. A reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_id    <= '0;
    end else begin
      if (xfer) begin
        rr_ptr <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
      end
      if (adv) begin
        s1_valid  <= xfer;
        s1_id     <= grant_idx;
        s1_a      <= sel_a;
        s1_b      <= sel_b;
        out_valid <= s1_valid;
        out_real  <= prod_real;
        out_imag  <= prod_imag;
        out_id    <= s1_id;
      end
    end
  end

  assign busy = s1_valid | out_valid;

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed self-checking bench for cmul_arbiter (NUM_REQ=4, DATA_WIDTH=16).
// Inputs change #1 after the rising edge; outputs are compared once settled.
module tb_cmul_arbiter;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a_real, req_a_imag, req_b_real, req_b_imag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_real, out_imag;
  logic [IDW-1:0]   out_id;
  logic             busy;

  int tests = 0;
  int fails = 0;

  // Hand-computed products of the per-requester operand table used below.
  logic [15:0] exp_re [4] = '{16'h0000, 16'h1C00, 16'h0000, 16'hFFFF};
  logic [15:0] exp_im [4] = '{16'h4000, 16'h1000, 16'hFFFC, 16'h0000};

  cmul_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .ID_W(IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a_real(req_a_real),
    .req_a_imag(req_a_imag),
    .req_b_real(req_b_real),
    .req_b_imag(req_b_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real(out_real),
    .out_imag(out_imag),
    .out_id(out_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [15:0] ar, input logic [15:0] ai,
                               input logic [15:0] br, input logic [15:0] bi);
    req_a_real[i*DW +: DW] = ar;
    req_a_imag[i*DW +: DW] = ai;
    req_b_real[i*DW +: DW] = br;
    req_b_imag[i*DW +: DW] = bi;
  endtask

  task automatic checkResult(input string tag, input logic [1:0] id,
                             input logic [15:0] re, input logic [15:0] im);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_id"},    32'(out_id),    32'(id));
    checkOutput({tag, "_real"},  32'(out_real),  32'(re));
    checkOutput({tag, "_imag"},  32'(out_imag),  32'(im));
  endtask

  task automatic loadTable();
    applyStimulus(0, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    applyStimulus(1, 16'h2000, 16'h3000, 16'h4000, 16'hE000);
    applyStimulus(2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    applyStimulus(3, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000);
  endtask

  initial begin
    // Reset: ready forced low even with every requester valid.
    rst        = 1'b1;
    out_ready  = 1'b1;
    req_valid  = 4'b1111;
    req_a_real = '0;
    req_a_imag = '0;
    req_b_real = '0;
    req_b_imag = '0;
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    checkOutput("rst_ready2",    32'(req_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_busy",      32'(busy),      32'h0);
    checkOutput("rst_out_real",  32'(out_real),  32'h0);
    checkOutput("rst_out_imag",  32'(out_imag),  32'h0);
    checkOutput("rst_out_id",    32'(out_id),    32'h0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single request from requester 2: 0.5 * 0.5 = 0.25, two cycles later.
    applyStimulus(2, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    req_valid = 4'b0100;
    #1;
    checkOutput("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    checkOutput("single_lat1_valid", 32'(out_valid), 32'h0);
    checkOutput("single_lat1_busy",  32'(busy),      32'h1);
    tick();
    checkResult("single", 2'd2, 16'h2000, 16'h0000);
    tick();
    checkOutput("single_drain", 32'(out_valid), 32'h0);

    // Pointer now 3: requester 3 alone, then 0 wins over 3 after the wrap.
    // Also exercises -1 * -1 saturation and a sum-only result.
    applyStimulus(3, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
    applyStimulus(0, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    req_valid = 4'b1000;
    #1;
    checkOutput("ptr_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b1001;
    #1;
    checkOutput("ptr_wrap_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    checkResult("sat", 2'd3, 16'h7FFF, 16'h0000);
    tick();
    checkResult("sum", 2'd0, 16'h0000, 16'h4000);
    tick();
    checkOutput("ptr_drain", 32'(out_valid), 32'h0);

    // Fairness from reset: all four valid for eight transfers.
    loadTable();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      if (cyc == 8) begin
        req_valid = 4'b0000;
        #1;
      end
      checkOutput($sformatf("fair_ready_%0d", cyc), 32'(req_ready),
                  (cyc < 8) ? (32'd1 << (cyc % 4)) : 32'd0);
      if (cyc >= 2 && cyc < 10) begin
        checkResult($sformatf("fair_%0d", cyc), 2'((cyc - 2) % 4),
                    exp_re[(cyc - 2) % 4], exp_im[(cyc - 2) % 4]);
      end else begin
        checkOutput($sformatf("fair_idle_%0d", cyc), 32'(out_valid), 32'h0);
      end
      tick();
    end

    // Backpressure with a full pipeline (S2 = id0, S1 = id1).
    req_valid = 4'b1111;
    #1;
    checkOutput("bp_fill_ready0", 32'(req_ready), 32'b0001);
    tick();
    checkOutput("bp_fill_ready1", 32'(req_ready), 32'b0010);
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("bp_ready_low", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkResult($sformatf("bp_hold_%0d", k), 2'd0, exp_re[0], exp_im[0]);
      checkOutput($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
      checkOutput($sformatf("bp_busy_%0d", k),  32'(busy),      32'h1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    checkResult("bp_after1", 2'd1, exp_re[1], exp_im[1]);
    tick();
    checkResult("bp_after2", 2'd2, exp_re[2], exp_im[2]);
    tick();
    checkOutput("bp_drain", 32'(out_valid), 32'h0);

    // Reset mid-flight: S2 = id3, S1 = id0 are discarded; pointer back to 0.
    req_valid = 4'b1111;
    #1;
    checkOutput("mid_ready3", 32'(req_ready), 32'b1000);
    tick();
    checkOutput("mid_ready0", 32'(req_ready), 32'b0001);
    tick();
    checkOutput("mid_full_valid", 32'(out_valid), 32'h1);
    checkOutput("mid_full_busy",  32'(busy),      32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    checkOutput("mid_out_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_busy",      32'(busy),      32'h0);
    checkOutput("mid_ptr_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    checkOutput("mid_no_stale", 32'(out_valid), 32'h0);
    tick();
    checkResult("mid_result", 2'd0, exp_re[0], exp_im[0]);
    tick();
    checkOutput("mid_drain_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_drain_busy",  32'(busy),      32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
